// File: rtl/lisp_pkg.sv
// Shared types for the Lisp expression evaluator: expression tags, FSM states,
// error codes, word-field geometry and the memory request bundle passed from
// the evaluator FSM to the memory request controller.
package lisp_pkg;

    // Default field geometry of an expression word:
    // [WORD_W-1] reserved, [WORD_W-2 -: TAG_W] tag, [ADDR_W-1:0] address.
    localparam int TAG_W_DEF  = 3;
    localparam int ADDR_W_DEF = 12;
    localparam int WORD_W_DEF = 1 + TAG_W_DEF + ADDR_W_DEF;

    // Width of the address carried in a request bundle; ADDR_W must not exceed it.
    localparam int ADDR_MAX_W = 32;

    typedef enum logic [2:0] {
        TAG_NUMBER = 3'd0,
        TAG_NIL    = 3'd1,
        TAG_CONS   = 3'd2
    } tag_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_MEM_WAIT,
        S_EVAL_CONST,
        S_LIST_CAR,
        S_LIST_ELEM,
        S_LIST_CDR,
        S_DONE,
        S_ERROR
    } eval_state_t;

    typedef enum logic [1:0] {
        ERR_NONE       = 2'd0,
        ERR_BAD_TAG    = 2'd1,
        ERR_BAD_CDR    = 2'd2,
        ERR_STEP_LIMIT = 2'd3
    } err_code_t;

    // One read request: where to read and which state consumes the word.
    typedef struct packed {
        logic                  active;
        logic [ADDR_MAX_W-1:0] address;
        eval_state_t           continue_state;
    } mem_req_t;

endpackage

// File: rtl/lisp_eval_core_if.sv
// Memory read bus of the evaluator: one-cycle request with held address,
// answered by a one-cycle ready pulse carrying the data word.
interface lisp_eval_core_if #(
    parameter int ADDR_W = 12,
    parameter int WORD_W = 16
) ();
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ready;
    logic [WORD_W-1:0] mem_data;

    modport master (output mem_req, output mem_addr, input mem_ready, input mem_data);
    modport slave  (input mem_req, input mem_addr, output mem_ready, output mem_data);
endinterface

// File: rtl/lisp_eval_core_mem_req_ctrl.sv
// Memory request controller: turns a request bundle into a one-cycle mem_req
// pulse, holds the address until mem_ready, remembers the continuation state
// and captures the returned word. resume_o tells the FSM where to go next.
module mem_req_ctrl
    import lisp_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int WORD_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  mem_req_t                req_i,
    output logic                    resume_o,
    output eval_state_t             next_state_o,
    output logic [WORD_W-1:0]       data_o,
    lisp_eval_core_if.master        mem
);

    if (ADDR_W > ADDR_MAX_W) begin : g_addr_w_check
        $error("mem_req_ctrl: ADDR_W (%0d) exceeds ADDR_MAX_W (%0d)", ADDR_W, ADDR_MAX_W);
    end

    logic              req_q;
    logic              wait_q;
    logic [ADDR_W-1:0] addr_q;
    eval_state_t       cont_q;
    logic [WORD_W-1:0] data_q;

    // Upper request-address bits beyond ADDR_W carry no information.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_i.address;

    // A mem_ready that arrives while nothing is outstanding (e.g. after reset) is dropped.
    assign resume_o     = wait_q & mem.mem_ready;
    assign next_state_o = cont_q;
    assign data_o       = data_q;
    assign mem.mem_req  = req_q;
    assign mem.mem_addr = addr_q;

    // Request pulse, outstanding flag, held address, continuation and data capture.
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q  <= 1'b0;
            wait_q <= 1'b0;
            addr_q <= '0;
            cont_q <= S_IDLE;
            data_q <= '0;
        end else begin
            req_q <= req_i.active;
            if (req_i.active) begin
                wait_q <= 1'b1;
                addr_q <= req_i.address[ADDR_W-1:0];
                cont_q <= req_i.continue_state;
            end else if (resume_o) begin
                wait_q <= 1'b0;
            end
            if (resume_o) begin
                data_q <= mem.mem_data;
            end
        end
    end

endmodule

// File: rtl/lisp_eval_core.sv
// Lisp expression evaluator: evaluates one tagged root word per start.
// NIL -> 0, NUMBER -> one indirect read, CONS list of NUMBERs -> walked and
// summed modulo 2^WORD_W. Optional macro EVAL_TRACE_EN enables the `reads`
// counter of memory requests issued since the last accepted start.
module lisp_eval_core
    import lisp_pkg::*;
#(
    parameter int TAG_W     = TAG_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int WORD_W    = WORD_W_DEF,
    parameter int MAX_STEPS = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WORD_W-1:0] root_expr,
    lisp_eval_core_if.master  mem,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [WORD_W-1:0] result,
    output logic [15:0]       reads
);

    if (WORD_W != 1 + TAG_W + ADDR_W) begin : g_word_w_check
        $error("lisp_eval_core: WORD_W (%0d) must equal 1+TAG_W+ADDR_W (%0d)",
               WORD_W, 1 + TAG_W + ADDR_W);
    end

    localparam int STEP_W = $clog2(MAX_STEPS + 1);
    localparam logic [TAG_W-1:0] T_NUMBER = TAG_W'(TAG_NUMBER);
    localparam logic [TAG_W-1:0] T_NIL    = TAG_W'(TAG_NIL);
    localparam logic [TAG_W-1:0] T_CONS   = TAG_W'(TAG_CONS);

    eval_state_t       state_q, state_d;
    logic [WORD_W-1:0] expr_q, expr_d;
    logic [WORD_W-1:0] acc_q, acc_d;
    logic [WORD_W-1:0] result_q, result_d;
    logic [STEP_W-1:0] steps_q, steps_d;
    err_code_t         err_q, err_d;

    mem_req_t          req;
    logic              resume;
    eval_state_t       next_state;
    logic [WORD_W-1:0] data;

    logic [TAG_W-1:0]  expr_tag, data_tag;
    logic [ADDR_W-1:0] expr_addr, data_addr;
    logic [STEP_W:0]   steps_inc;
    logic              accept;

    assign expr_tag  = expr_q[WORD_W-2 -: TAG_W];
    assign expr_addr = expr_q[ADDR_W-1:0];
    assign data_tag  = data[WORD_W-2 -: TAG_W];
    assign data_addr = data[ADDR_W-1:0];
    assign steps_inc = {1'b0, steps_q} + (STEP_W + 1)'(1);

    // The reserved top bit of an expression word is carried but never interpreted.
    logic unused_reserved;
    assign unused_reserved = expr_q[WORD_W-1];

    assign busy     = !(state_q inside {S_IDLE, S_DONE, S_ERROR});
    assign accept   = start && !busy;
    assign done     = (state_q == S_DONE);
    assign error    = (state_q == S_ERROR);
    assign err_code = err_q;
    assign result   = result_q;

    mem_req_ctrl #(
        .ADDR_W (ADDR_W),
        .WORD_W (WORD_W)
    ) u_mem_req_ctrl (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_i        (req),
        .resume_o     (resume),
        .next_state_o (next_state),
        .data_o       (data),
        .mem          (mem)
    );

    // Evaluator FSM: next state, datapath updates and memory requests.
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d            = state_q;
        expr_d             = expr_q;
        acc_d              = acc_q;
        result_d           = result_q;
        steps_d            = steps_q;
        err_d              = err_q;
        req.active         = 1'b0;
        req.address        = '0;
        req.continue_state = S_IDLE;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (accept) begin
                    expr_d  = root_expr;
                    acc_d   = '0;
                    steps_d = '0;
                    err_d   = ERR_NONE;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (expr_tag == T_NUMBER || expr_tag == T_CONS) begin
                    req.active         = 1'b1;
                    req.address        = ADDR_MAX_W'(expr_addr);
                    req.continue_state = (expr_tag == T_NUMBER) ? S_EVAL_CONST : S_LIST_CAR;
                    state_d            = S_MEM_WAIT;
                end else if (expr_tag == T_NIL) begin
                    result_d = '0;
                    state_d  = S_DONE;
                end else begin
                    err_d   = ERR_BAD_TAG;
                    state_d = S_ERROR;
                end
            end
            S_MEM_WAIT: begin
                if (resume) state_d = next_state;
            end
            S_EVAL_CONST: begin
                result_d = data;
                state_d  = S_DONE;
            end
            S_LIST_CAR: begin
                if (data_tag == T_NUMBER) begin
                    req.active         = 1'b1;
                    req.address        = ADDR_MAX_W'(data_addr);
                    req.continue_state = S_LIST_ELEM;
                    state_d            = S_MEM_WAIT;
                end else begin
                    err_d   = ERR_BAD_TAG;
                    state_d = S_ERROR;
                end
            end
            S_LIST_ELEM: begin
                acc_d              = acc_q + data;
                req.active         = 1'b1;
                req.address        = ADDR_MAX_W'(expr_addr + ADDR_W'(1));
                req.continue_state = S_LIST_CDR;
                state_d            = S_MEM_WAIT;
            end
            S_LIST_CDR: begin
                if (data_tag == T_NIL) begin
                    result_d = acc_q;
                    state_d  = S_DONE;
                end else if (data_tag == T_CONS) begin
                    steps_d = steps_inc[STEP_W-1:0];
                    if (steps_inc >= (STEP_W + 1)'(MAX_STEPS)) begin
                        err_d   = ERR_STEP_LIMIT;
                        state_d = S_ERROR;
                    end else begin
                        expr_d  = data;
                        state_d = S_FETCH;
                    end
                end else begin
                    err_d   = ERR_BAD_CDR;
                    state_d = S_ERROR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Evaluator state and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            expr_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
            steps_q  <= '0;
            err_q    <= ERR_NONE;
        end else begin
            state_q  <= state_d;
            expr_q   <= expr_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            steps_q  <= steps_d;
            err_q    <= err_d;
        end
    end

`ifdef EVAL_TRACE_EN
    logic [15:0] reads_q;

    // Saturating count of memory requests since the last accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reads_q <= '0;
        end else if (accept) begin
            reads_q <= '0;
        end else if (req.active && reads_q != 16'hFFFF) begin
            reads_q <= reads_q + 16'd1;
        end
    end

    assign reads = reads_q;
`else
    assign reads = '0;
`endif

endmodule
